btn_conditioner: RTL and testbench

- Input conditioning stage between the raw ULX3S buttons and the per-frame control logic (box mover, reset).
- Synchronises, polarity-corrects and debounces each button.
- Emits a clean level plus one-cycle press, release and auto-repeat strobes in the pixel clock domain.
- Downstream logic consumes strobes instead of sampling raw `btn` on vsync.

---
 rtl/btn_conditioner.sv | 135 +++++++++++++
 tb/tb_btn_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button input conditioner: per-button polarity fix, 2-FF sync, debounce,
// and registered press/release/auto-repeat strobes in the pixel clock domain.

module btn_lane #(
    parameter logic INV             = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter int   REPEAT_DELAY    = 12500000,
    parameter int   REPEAT_PERIOD   = 2500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_rel,
    output logic o_rpt
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, RPT} rstate_t;

    logic          r_s1, r_s2;
    logic          r_level, r_press, r_rel, r_rpt;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    rstate_t       r_state;

    logic w_toggle, w_rise, w_fall;

    // Level flips on the last cycle of an unbroken mismatch run.
    assign w_toggle = (r_s2 != r_level) && (r_dcnt == DEB_LAST);
    assign w_rise   = w_toggle & ~r_level;
    assign w_fall   = w_toggle &  r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_s1    <= i_btn ^ INV;
            r_s2    <= r_s1;
            r_press <= w_rise;
            r_rel   <= w_fall;
            if (r_s2 == r_level)
                r_dcnt <= '0;
            else if (w_toggle) begin
                r_level <= ~r_level;
                r_dcnt  <= '0;
            end else
                r_dcnt <= r_dcnt + DW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_rpt   <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            // Release wins over a repeat expiring on the same edge.
            if (w_fall) begin
                r_state <= IDLE;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: if (w_rise) begin
                        r_rpt  <= 1'b1;
                        r_rcnt <= '0;
                        if (REPEAT_DELAY != 0) r_state <= DELAY;
                    end
                    DELAY: if (r_rcnt == DLY_LAST) begin
                        r_rpt   <= 1'b1;
                        r_rcnt  <= '0;
                        r_state <= RPT;
                    end else
                        r_rcnt <= r_rcnt + RW'(1);
                    RPT: if (r_rcnt == PER_LAST) begin
                        r_rpt  <= 1'b1;
                        r_rcnt <= '0;
                    end else
                        r_rcnt <= r_rcnt + RW'(1);
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;
    assign o_rel   = r_rel;
    assign o_rpt   = r_rpt;
endmodule

module btn_conditioner #(
    parameter int               N_BTN           = 8,
    parameter logic [N_BTN-1:0] INVERT_MASK     = {{(N_BTN-1){1'b0}}, 1'b1},
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               REPEAT_DELAY    = 12500000,
    parameter int               REPEAT_PERIOD   = 2500000
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);
    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        btn_lane #(
            .INV            (INVERT_MASK[g]),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .i_clk  (clk_25mhz),
            .i_rst  (rst),
            .i_btn  (btn_in[g]),
            .o_level(btn_level[g]),
            .o_press(btn_press[g]),
            .o_rel  (btn_release[g]),
            .o_rpt  (btn_repeat[g])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.

module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn_in;
    logic [7:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN(8), .INVERT_MASK(8'h01),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk_25mhz  (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves all lanes idle; the caller's next input change is edge 0.
    task automatic do_reset();
        rst    = 1'b1;
        btn_in = 8'h01;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] act;
        rst    = 1'b1;
        btn_in = 8'h01;
        for (int e = 0; e < 3; e++) tick();
        act = {btn_level, btn_press, btn_release, btn_repeat};
        checks++;
        if (act !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", act, 32'h0);
        end
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle e=%0d got %h want %h", e, act, 32'h0);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] act, exp;
        logic [7:0]  l, p, r, q;
        do_reset();
        btn_in[3] = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            tick();
            l = (e >= 6 && e < 30) ? 8'h08 : 8'h00;
            p = (e == 6) ? 8'h08 : 8'h00;
            r = (e == 30) ? 8'h08 : 8'h00;
            q = (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28) ? 8'h08 : 8'h00;
            exp = {l, p, r, q};
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL clean_press e=%0d got %h want %h", e, act, exp);
            end
            if (e == 24) btn_in[3] = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic [31:0] act;
        do_reset();
        btn_in[5] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) btn_in[5] = 1'b0;
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== 32'h0) begin
                errors++;
                $display("FAIL glitch e=%0d got %h want %h", e, act, 32'h0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [31:0] act, exp;
        logic [7:0]  l, p, r, q;
        logic [6:0]  seq;
        seq = 7'b1111101;
        do_reset();
        btn_in[4] = seq[0];
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e < 7) btn_in[4] = seq[e];
            if (e == 14) btn_in[4] = 1'b0;
            l = (e >= 8 && e < 20) ? 8'h10 : 8'h00;
            p = (e == 8) ? 8'h10 : 8'h00;
            r = (e == 20) ? 8'h10 : 8'h00;
            q = (e == 8 || e == 18) ? 8'h10 : 8'h00;
            exp = {l, p, r, q};
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL bounce e=%0d got %h want %h", e, act, exp);
            end
        end
    endtask

    task automatic test_release_collision();
        logic [31:0] act, exp;
        logic [7:0]  l, p, r, q;
        do_reset();
        btn_in[6] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 16) btn_in[6] = 1'b0;
            l = (e >= 6 && e < 22) ? 8'h40 : 8'h00;
            p = (e == 6) ? 8'h40 : 8'h00;
            r = (e == 22) ? 8'h40 : 8'h00;
            q = (e == 6 || e == 16 || e == 19) ? 8'h40 : 8'h00;
            exp = {l, p, r, q};
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL release_collision e=%0d got %h want %h", e, act, exp);
            end
        end
    endtask

    task automatic test_active_low();
        logic [31:0] act, exp;
        logic [7:0]  l, p, r, q;
        do_reset();
        btn_in[0] = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 8) btn_in[0] = 1'b1;
            l = (e >= 6 && e < 14) ? 8'h01 : 8'h00;
            p = (e == 6) ? 8'h01 : 8'h00;
            r = (e == 14) ? 8'h01 : 8'h00;
            q = (e == 6) ? 8'h01 : 8'h00;
            exp = {l, p, r, q};
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL active_low e=%0d got %h want %h", e, act, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [31:0] act, exp;
        logic [7:0]  l, p, q;
        do_reset();
        btn_in[3] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 20) rst = 1'b1;
            if (e == 22) rst = 1'b0;
            if (e <= 20) begin
                l = (e >= 6) ? 8'h08 : 8'h00;
                p = (e == 6) ? 8'h08 : 8'h00;
                q = (e == 6 || e == 16 || e == 19) ? 8'h08 : 8'h00;
            end else begin
                l = (e >= 28) ? 8'h08 : 8'h00;
                p = (e == 28) ? 8'h08 : 8'h00;
                q = (e == 28 || e == 38) ? 8'h08 : 8'h00;
            end
            exp = {l, p, 8'h00, q};
            act = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reset_mid_hold e=%0d got %h want %h", e, act, exp);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 8'h01;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_release_collision();
        test_active_low();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
